// File: rtl/dmem_arbiter_if.sv
// Two-port data memory request bus: requesters drive req/we/addr/wdata, arbiter returns gnt/done/rdata/busy.
// Interface bundle only; no timing or backpressure of its own.
interface dmem_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 4
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt0;
  logic          gnt1;
  logic          done0;
  logic          done1;
  logic [DW-1:0] rdata;
  logic          busy;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, gnt1, done0, done1, rdata, busy
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, gnt1, done0, done1, rdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter over a shared DEPTH x DW memory; gnt at N+1, done at N+2, one access per 3 cycles.
// Requesters hold their command until gnt; define DMEM_ARBITER_FIXED_PRI_EN for fixed priority (port 0 wins ties).
module dmem_arbiter #(
  parameter int DW    = 16,
  parameter int AW    = 4,
  parameter int DEPTH = 16
) (
  input  logic           clock,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          capture;
  logic          winner;
  logic          cap_port;
  logic          cap_we;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_wdata;
  logic [DW-1:0] rdata_q;
  logic          gnt0_c;
  logic          gnt1_c;
  logic          done0_c;
  logic          done1_c;

  logic [DW-1:0] mem [DEPTH];

`ifdef DMEM_ARBITER_FIXED_PRI_EN
  assign winner = ~bus.req0;
`else
  logic last_gnt;

  // On a tie the port that did not win last time goes next.
  assign winner = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (capture) begin
      last_gnt <= winner;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    gnt0_c    = 1'b0;
    gnt1_c    = 1'b0;
    done0_c   = 1'b0;
    done1_c   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          capture   = 1'b1;
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        gnt0_c    = ~cap_port;
        gnt1_c    = cap_port;
        state_nxt = RESP;
      end
      RESP: begin
        // A reset landing in the response cycle swallows the completion.
        done0_c   = ~cap_port & ~reset;
        done1_c   = cap_port & ~reset;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (capture) begin
      cap_port  <= winner;
      cap_we    <= winner ? bus.we1    : bus.we0;
      cap_addr  <= winner ? bus.addr1  : bus.addr0;
      cap_wdata <= winner ? bus.wdata1 : bus.wdata0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && state == ACCESS && cap_we) begin
      mem[cap_addr] <= cap_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      rdata_q <= cap_we ? cap_wdata : mem[cap_addr];
    end
  end

  assign bus.gnt0  = gnt0_c;
  assign bus.gnt1  = gnt1_c;
  assign bus.done0 = done0_c;
  assign bus.done1 = done1_c;
  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: latency, read-back, round-robin/fixed order, reset abort, boundaries, input hold.
module tb_dmem_arbiter;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  dmem_arbiter_if #(.DW(16), .AW(4)) bus ();

  dmem_arbiter #(.DW(16), .AW(4), .DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  // Runs one complete access and reports what the port saw in the gnt and done cycles.
  task automatic do_access(input logic port, input logic we, input logic [3:0] addr,
                           input logic [15:0] wd, output logic g, output logic d,
                           output logic [15:0] rd);
    if (port) begin
      bus.req1 = 1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end else begin
      bus.req0 = 1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end
    tick();
    g = port ? (bus.gnt1 && !bus.gnt0) : (bus.gnt0 && !bus.gnt1);
    idle_inputs();
    tick();
    d  = port ? (bus.done1 && !bus.done0) : (bus.done0 && !bus.done1);
    rd = bus.rdata;
    tick();
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    vectors++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 00000", {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy});
    end
    vectors++;
    if (bus.rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h want 0000", bus.rdata);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_write_latency();
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd3; bus.wdata0 = 16'hA5A5;
    tick();
    vectors++;
    if ({bus.gnt0, bus.gnt1, bus.done0, bus.busy} !== 4'b1001) begin
      miscompares++;
      $display("FAIL wr_gnt_cycle: got gnt0,gnt1,done0,busy=%b want 1001", {bus.gnt0, bus.gnt1, bus.done0, bus.busy});
    end
    idle_inputs();
    tick();
    vectors++;
    if ({bus.gnt0, bus.done0, bus.done1, bus.busy} !== 4'b0101) begin
      miscompares++;
      $display("FAIL wr_done_cycle: got gnt0,done0,done1,busy=%b want 0101", {bus.gnt0, bus.done0, bus.done1, bus.busy});
    end
    vectors++;
    if (bus.rdata !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL wr_rdata: got %h want a5a5", bus.rdata);
    end
    tick();
    vectors++;
    if ({bus.busy, bus.done0} !== 2'b00 || bus.rdata !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL wr_after: got busy,done0=%b rdata=%h want 00 a5a5", {bus.busy, bus.done0}, bus.rdata);
    end
  endtask

  task automatic test_read_port1();
    logic g, d;
    logic [15:0] rd;
    do_access(1'b1, 1'b0, 4'd3, 16'h0000, g, d, rd);
    vectors++;
    if (g !== 1'b1 || d !== 1'b1) begin
      miscompares++;
      $display("FAIL rd1_handshake: got gnt1=%b done1=%b want 1 1", g, d);
    end
    vectors++;
    if (rd !== 16'hA5A5) begin
      miscompares++;
      $display("FAIL rd1_data: got %h want a5a5", rd);
    end
  endtask

  task automatic test_arbitration();
    int   n;
    int   both;
    logic [3:0] seq;
    int   when [4];
    logic [3:0] exp_seq;
    reset = 1;
    tick();
    reset = 0;
    n = 0; both = 0; seq = '0;
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd1;
    bus.req1 = 1; bus.we1 = 0; bus.addr1 = 4'd2;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if ((bus.gnt0 && bus.gnt1) || (bus.done0 && bus.done1)) both++;
      if ((bus.gnt0 || bus.gnt1) && n < 4) begin
        seq[n]  = bus.gnt1;
        when[n] = c;
        n++;
      end
    end
    idle_inputs();
    tick();
`ifdef DMEM_ARBITER_FIXED_PRI_EN
    exp_seq = 4'b0000;
`else
    exp_seq = 4'b1010;
`endif
    vectors++;
    if (n !== 4 || seq !== exp_seq) begin
      miscompares++;
      $display("FAIL arb_order: got %0d grants seq(bit0 first)=%b want 4 %b", n, seq, exp_seq);
    end
    vectors++;
    if (n == 4 && (when[0] != 1 || when[1] != 4 || when[2] != 7 || when[3] != 10)) begin
      miscompares++;
      $display("FAIL arb_spacing: got cycles %0d %0d %0d %0d want 1 4 7 10", when[0], when[1], when[2], when[3]);
    end
    vectors++;
    if (both !== 0) begin
      miscompares++;
      $display("FAIL arb_exclusive: got %0d overlapping cycles want 0", both);
    end
  endtask

  task automatic test_reset_in_access();
    logic g, d;
    logic [15:0] rd;
    do_access(1'b0, 1'b1, 4'd15, 16'h0BAD, g, d, rd);
    bus.req0 = 1; bus.we0 = 1; bus.addr0 = 4'd15; bus.wdata0 = 16'h1234;
    tick();
    vectors++;
    if (bus.gnt0 !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_acc_gnt: got %b want 1", bus.gnt0);
    end
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    vectors++;
    if ({bus.done0, bus.done1, bus.busy} !== 3'b000 || bus.rdata !== 16'h0000) begin
      miscompares++;
      $display("FAIL rst_acc_abort: got done0,done1,busy=%b rdata=%h want 000 0000", {bus.done0, bus.done1, bus.busy}, bus.rdata);
    end
    tick();
    do_access(1'b0, 1'b0, 4'd15, 16'h0000, g, d, rd);
    vectors++;
    if (d !== 1'b1 || rd !== 16'h0BAD) begin
      miscompares++;
      $display("FAIL rst_acc_mem: got done0=%b rdata=%h want 1 0bad", d, rd);
    end
  endtask

  task automatic test_boundaries();
    logic g, d;
    logic [15:0] rd;
    do_access(1'b0, 1'b1, 4'd0,  16'hFFFF, g, d, rd);
    do_access(1'b1, 1'b1, 4'd15, 16'h0001, g, d, rd);
    do_access(1'b0, 1'b0, 4'd0,  16'h0000, g, d, rd);
    vectors++;
    if (rd !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL bound_addr0: got %h want ffff", rd);
    end
    do_access(1'b1, 1'b0, 4'd15, 16'h0000, g, d, rd);
    vectors++;
    if (rd !== 16'h0001) begin
      miscompares++;
      $display("FAIL bound_addr15: got %h want 0001", rd);
    end
  endtask

  task automatic test_hold_after_gnt();
    logic g, d;
    logic [15:0] rd;
    do_access(1'b0, 1'b1, 4'd5, 16'h5555, g, d, rd);
    do_access(1'b0, 1'b1, 4'd6, 16'h6666, g, d, rd);
    bus.req0 = 1; bus.we0 = 0; bus.addr0 = 4'd5;
    tick();
    bus.req0 = 0; bus.we0 = 1; bus.addr0 = 4'd6; bus.wdata0 = 16'hDEAD;
    tick();
    vectors++;
    if (bus.done0 !== 1'b1 || bus.rdata !== 16'h5555) begin
      miscompares++;
      $display("FAIL hold_read: got done0=%b rdata=%h want 1 5555", bus.done0, bus.rdata);
    end
    idle_inputs();
    tick();
    do_access(1'b1, 1'b0, 4'd6, 16'h0000, g, d, rd);
    vectors++;
    if (rd !== 16'h6666) begin
      miscompares++;
      $display("FAIL hold_nowrite: got %h want 6666", rd);
    end
  endtask

  task automatic test_back_to_back_raw();
    logic g, d;
    logic [15:0] rd;
    do_access(1'b1, 1'b1, 4'd9, 16'hC3C3, g, d, rd);
    do_access(1'b0, 1'b0, 4'd9, 16'h0000, g, d, rd);
    vectors++;
    if (g !== 1'b1 || d !== 1'b1 || rd !== 16'hC3C3) begin
      miscompares++;
      $display("FAIL raw_b2b: got gnt0=%b done0=%b rdata=%h want 1 1 c3c3", g, d, rd);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_write_latency();
    test_read_port1();
    test_arbitration();
    test_reset_in_access();
    test_boundaries();
    test_hold_after_gnt();
    test_back_to_back_raw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DW, default 16, data word width in bits.
REQ-002 Parameter AW, default 4, address width in bits.
REQ-003 Parameter DEPTH, default 16, number of data memory words, equal to 2**AW.
REQ-004 clock  input  1  rising-edge system clock; all state SHALL change only on this edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req0 / req1  input  1 each  access request from port 0 (processor core) / port 1 (host).
REQ-007 we0 / we1  input  1 each  1 = write, 0 = read, qualified by reqN.
REQ-008 addr0 / addr1  input  AW each  word address, qualified by reqN.
REQ-009 wdata0 / wdata1  input  DW each  write data, qualified by reqN and weN.
REQ-010 gnt0 / gnt1  output  1 each  one-cycle grant pulse; the port's command has been captured.
REQ-011 done0 / done1  output  1 each  one-cycle completion pulse.
REQ-012 rdata  output  DW  read data, valid only while done0 or done1 is high.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL own a DEPTH x DW data memory array shared by both ports.
REQ-015 The FSM SHALL have the states IDLE, ACCESS and RESP; any other encoding SHALL return to IDLE on the next edge.
REQ-016 IDLE: if req0 or req1 is high at an edge, the block SHALL arbitrate, capture the winner's we/addr/wdata and port ID, and go to ACCESS; otherwise it SHALL stay in IDLE.
REQ-017 ACCESS: gntN SHALL be high for the winning port for exactly this cycle; the captured write SHALL commit at the closing edge, or the read data SHALL be registered at that edge; the next state SHALL be RESP.
REQ-018 RESP: doneN SHALL be high for the winning port for exactly this cycle; for a read, rdata SHALL hold mem[addr]; for a write, rdata SHALL hold the written data; the next state SHALL be IDLE.
REQ-019 Latency: a request sampled at edge N SHALL give gnt in cycle N+1, done in cycle N+2, and allow the next arbitration at edge N+3; the block SHALL complete one access per 3 cycles.
REQ-020 A requester SHALL hold reqN, weN, addrN and wdataN stable until gntN and may deassert them in the gnt cycle; the block SHALL ignore these inputs outside IDLE.
REQ-021 Round-robin: the block SHALL keep a last-granted register; when both ports request, the port not last granted SHALL win; a single requester SHALL always win.
REQ-022 With req0 and req1 both held high continuously, grants SHALL strictly alternate 0,1,0,1 starting with port 0 after reset.
REQ-023 A read of an address written by the immediately preceding access SHALL return the new data.
REQ-024 gnt0/gnt1 SHALL never be high together, and done0/done1 SHALL never be high together.
REQ-025 rdata SHALL hold its last value outside RESP.

Reset
REQ-026 On reset, state = IDLE, last-granted = port 1 (so port 0 wins the first tie), gnt0 = gnt1 = done0 = done1 = busy = 0, and rdata = 0.
REQ-027 Reset in ACCESS SHALL take precedence and suppress the pending write; reset in RESP SHALL suppress done.
REQ-028 Reset SHALL NOT clear the memory array contents.

Configuration
REQ-029 With macro DMEM_ARBITER_FIXED_PRI_EN defined, arbitration SHALL be fixed priority with port 0 always winning ties, and the last-granted register SHALL be omitted.
REQ-030 With DMEM_ARBITER_FIXED_PRI_EN undefined, round-robin per REQ-021/022 SHALL apply; all other behaviour SHALL be identical in both builds.

Verification
REQ-031 After reset, req0=1, we0=1, addr0=3, wdata0=16'hA5A5 for one cycle -> gnt0 high in the next cycle, done0 the cycle after, busy high for 2 cycles.
REQ-032 Then req1=1, we1=0, addr1=3 -> gnt1, then done1 with rdata=16'hA5A5.
REQ-033 req0 and req1 held high for 12 cycles -> grant sequence 0,1,0,1 (4 grants, 3-cycle spacing); with DMEM_ARBITER_FIXED_PRI_EN defined -> 0,0,0,0.
REQ-034 Write addr 15 = 16'h1234 by port 0, with reset pulsed in the ACCESS cycle -> no done; a subsequent read of addr 15 returns the prior value.
REQ-035 Write 16'hFFFF to addr 0 then 16'h0001 to addr 15, then read addr 0 and addr 15 -> rdata 16'hFFFF then 16'h0001 (no aliasing at the boundaries).
REQ-036 Change addr0 after gnt0 while in RESP -> the completed access is unaffected and rdata matches the originally captured address.
